// File: rtl/bp_update_sched_if.sv
// rtl/bp_update_sched_if.sv - resolution inputs and predictor update port bundle
interface bp_update_sched_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                     res0_valid;
  logic [15:0]              res0_pc;
  logic                     res0_taken;
  logic                     res0_pred;
  logic                     res1_valid;
  logic [15:0]              res1_pc;
  logic                     res1_taken;
  logic                     res1_pred;
  logic                     res_ready;
  logic                     upd_rectify;
  logic                     upd_result;
  logic [15:0]              upd_pc;
  logic [$clog2(DEPTH):0]   q_count;
  logic [CNT_W-1:0]         mispred_cnt;

  // Execute pipes and observers drive resolutions and watch the update port
  modport master (
    output res0_valid, res0_pc, res0_taken, res0_pred,
    output res1_valid, res1_pc, res1_taken, res1_pred,
    input  res_ready, upd_rectify, upd_result, upd_pc, q_count, mispred_cnt
  );

  // The scheduler consumes resolutions and drives the predictor update port
  modport slave (
    input  res0_valid, res0_pc, res0_taken, res0_pred,
    input  res1_valid, res1_pc, res1_taken, res1_pred,
    output res_ready, upd_rectify, upd_result, upd_pc, q_count, mispred_cnt
  );
endinterface

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - queues dual-pipe branch resolutions onto a single held predictor update port
module bp_update_sched #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  bp_update_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  // Entry layout: {pc[15:0], taken}
  logic [16:0]       mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [0:0]        state;
  logic [HW-1:0]     hold_cnt;
  logic              rectify_q;
  logic              result_q;
  logic [15:0]       pc_q;
  logic [CNT_W-1:0]  mispred_q;

  logic              res_ready;
  logic              acc0;
  logic              acc1;
  logic [1:0]        n_acc;
  logic [1:0]        mis_inc;
  logic [CNT_W:0]    mis_sum;
  logic [16:0]       entry0;
  logic [16:0]       entry1;
  logic [16:0]       next_head;
  logic              pop;
  logic              more;

  // Ready looks only at registered occupancy; a same-cycle pop is not credited
  assign res_ready = (count <= CW'(DEPTH - 2));
  assign acc0      = res_ready & bus.res0_valid;
  assign acc1      = res_ready & bus.res1_valid;
  assign n_acc     = {1'b0, acc0} + {1'b0, acc1};
  assign entry0    = {bus.res0_pc, bus.res0_taken};
  assign entry1    = {bus.res1_pc, bus.res1_taken};

  assign mis_inc   = {1'b0, acc0 & (bus.res0_taken ^ bus.res0_pred)}
                   + {1'b0, acc1 & (bus.res1_taken ^ bus.res1_pred)};
  assign mis_sum   = {1'b0, mispred_q} + (CNT_W + 1)'(mis_inc);

  // Pop on the edge that ends the last hold cycle
  assign pop  = (state == S_ISSUE) && (hold_cnt == HW'(HOLD - 1));
  // Something remains after the pop, counting entries written on the same edge
  assign more = (count > CW'(1)) || (n_acc != 2'd0);
  // The entry behind the head, or the incoming one when the queue would otherwise drain
  assign next_head = (count > CW'(1)) ? mem[rd_ptr + PW'(1)]
                                      : (acc0 ? entry0 : entry1);

  assign bus.res_ready   = res_ready;
  assign bus.upd_rectify = rectify_q;
  assign bus.upd_result  = result_q;
  assign bus.upd_pc      = pc_q;
  assign bus.q_count     = count;
  assign bus.mispred_cnt = mispred_q;

  // Queue storage: pipe 0 lands before pipe 1 when both are accepted
  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr] <= entry0;
    if (acc1) mem[wr_ptr + PW'(acc0)] <= entry1;
  end

  // Pointers and occupancy; enqueue and pop may both happen on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_acc);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(n_acc) - CW'(pop);
    end
  end

  // Issue FSM: holds each update for HOLD cycles, reloading back-to-back when more are queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      rectify_q <= 1'b0;
      result_q  <= 1'b0;
      pc_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rectify_q <= 1'b0;
          if (count != '0) begin
            pc_q      <= mem[rd_ptr][16:1];
            result_q  <= mem[rd_ptr][0];
            rectify_q <= 1'b1;
            hold_cnt  <= '0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (pop) begin
            if (more) begin
              pc_q     <= next_head[16:1];
              result_q <= next_head[0];
              hold_cnt <= '0;
            end else begin
              rectify_q <= 1'b0;
              state     <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          rectify_q <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating mispredict counter over accepted resolutions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mispred_q <= '0;
    else     mispred_q <= mis_sum[CNT_W] ? '1 : mis_sum[CNT_W-1:0];
  end
endmodule

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Schedules branch-resolution updates from the two superscalar execute pipes onto the branch predictor's single update port (old_br_rectify / old_br_result / old_br_pc).
- The predictor does a read-modify-write through an internal staging register, so each update must be held stable for HOLD consecutive cycles to land correctly.
- The block buffers up to two resolutions per cycle in a small in-order queue.
- It issues queued updates one at a time, each held for HOLD cycles, and keeps a saturating mispredict count for performance monitoring.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- HOLD, 2, cycles each update is held on the predictor port; ≥1.
- CNT_W, 16, mispredict counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- res0_valid  in  1  pipe 0 resolved a branch this cycle
- res0_pc  in  16  pipe 0 branch PC
- res0_taken  in  1  pipe 0 actual outcome (1 = taken)
- res0_pred  in  1  pipe 0 predicted outcome
- res1_valid, res1_pc, res1_taken, res1_pred  in  1/16/1/1  same fields for pipe 1
- res_ready  out  1  queue can accept two entries this cycle
- upd_rectify  out  1  to predictor old_br_rectify
- upd_result  out  1  to predictor old_br_result
- upd_pc  out  16  to predictor old_br_pc
- q_count  out  $clog2(DEPTH)+1  occupied entries
- mispred_cnt  out  CNT_W  accepted resolutions with pred != taken, saturating

Behaviour:
- Reset (async): queue empty, pointers 0, q_count = 0, FSM = IDLE, upd_rectify = 0, upd_result = 0, upd_pc = 0, mispred_cnt = 0. Outputs drop immediately on rst, including mid-hold; the in-flight update is abandoned.
- res_ready = (DEPTH - q_count) ≥ 2.
  - Combinational from registered state only.
  - Does not credit a pop in the same cycle (conservative).
- Enqueue on a clock edge when res_ready = 1:
  - res0 is written before res1 if both are valid; a lone valid takes one slot.
  - Entry contents = {pc, taken}.
  - A res*_valid with res_ready = 0 is ignored, not enqueued and not counted. The sender must hold the request.
- mispred_cnt increments by the number of accepted entries (0/1/2) with pred != taken. It saturates at all-ones with no wrap; +2 from all-ones-minus-1 gives all-ones.
- Pointers wrap modulo DEPTH. Full = q_count == DEPTH; empty = q_count == 0.
- FSM:
  - IDLE: upd_rectify = 0. If q_count > 0 at the edge, load head into upd_pc/upd_result, set upd_rectify = 1, hold counter = 0, go to ISSUE.
  - ISSUE: outputs stable; hold counter increments each cycle. On the edge ending cycle HOLD, pop the head.
    - If the queue still holds an entry after the pop (including one enqueued that same edge), load it back-to-back: upd_rectify stays 1, upd_pc/upd_result change, counter = 0, stay in ISSUE.
    - Otherwise clear upd_rectify and return to IDLE.
- Latency: an entry enqueued at edge N into an empty, idle block appears on the update port after edge N+1 and is held for HOLD cycles.
- Queue order is strictly FIFO; updates to the same PC index are never merged or reordered.
- Simultaneous enqueue and pop in one edge: both take effect; q_count changes by (enqueued - 1).
- upd_* are registered outputs with no combinational path from res* inputs.

Test Plan:
1. Reset, then res0 = {pc 0x0005, taken 1, pred 0} for one cycle -> upd_rectify high for 2 cycles starting the cycle after enqueue, upd_pc = 0x0005, upd_result = 1; mispred_cnt = 1; q_count returns to 0; FSM back to IDLE.
2. Both pipes valid in one cycle: res0 pc 0x0010 not-taken, res1 pc 0x0011 taken -> 0x0010/0 held 2 cycles, then 0x0011/1 held 2 cycles back-to-back with no rectify gap.
3. Fill test: dual enqueue 2 cycles running with DEPTH = 4 -> res_ready = 0 when q_count ≥ 3. A third dual request is ignored while held; it is accepted only after pops free two slots. All 6 updates appear in order.
4. Resolutions for the same PC 0x0003: taken, taken, not-taken -> three separate 2-cycle updates in that order, with no merging.
5. Assert rst mid-ISSUE (hold cycle 1) with q_count = 3 -> upd_rectify = 0 immediately, q_count = 0, mispred_cnt = 0. After release, no stale update is issued.
6. Preload mispred_cnt to 0xFFFE (force), then accept two mispredicted resolutions -> 0xFFFF. A further mispredict keeps it at 0xFFFF.
